// File: rtl/register_file_param.sv
// rtl/register_file_param.sv - parametrised 2R/1W register file with post-reset clear engine
// Optional write-through forwarding: define REGFILE_BYPASS_EN.
module register_file_param #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter int                ZERO_REG = 1,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              ready,
    output logic              wr_drop
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic                wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                zero_wr;

    assign zero_wr = (ZERO_REG != 0) && (write_reg == '0);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        wr_drop_d = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = write_reg;
        mem_wdata = write_data;
        if (state_q == CLEAR) begin
            // Clear engine owns the write port; user writes are only flagged.
            mem_we    = !rst;
            mem_waddr = clr_idx_q;
            mem_wdata = CLR_VAL;
            clr_idx_d = clr_idx_q + ADDR_W'(1);
            wr_drop_d = RegWrite;
            if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                state_d = READY;
            end
        end else begin
            mem_we = !rst && RegWrite && !zero_wr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Storage has no reset; the clear engine initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (state_q == READY) begin
            if (!((ZERO_REG != 0) && (read_reg1 == '0))) begin
                read_data1 = mem[read_reg1];
`ifdef REGFILE_BYPASS_EN
                if (RegWrite && (read_reg1 == write_reg)) read_data1 = write_data;
`endif
            end
            if (!((ZERO_REG != 0) && (read_reg2 == '0))) begin
                read_data2 = mem[read_reg2];
`ifdef REGFILE_BYPASS_EN
                if (RegWrite && (read_reg2 == write_reg)) read_data2 = write_data;
`endif
            end
        end
    end

    assign ready   = (state_q == READY);
    assign wr_drop = wr_drop_q;
endmodule
